sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl_pkg.sv | 14 +
 rtl/sync_fifo_ctrl_fifomem.sv | 32 +++
 rtl/sync_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants for the synchronous FIFO controller: default geometry
// and the derivation of the pointer width from the address width.
package sync_fifo_ctrl_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 4;

  // Pointers carry one extra bit beyond the memory address so that a full
  // FIFO and an empty FIFO are distinguishable from the pointers alone.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage : sync_fifo_ctrl_pkg

// File: rtl/sync_fifo_ctrl_fifomem.sv
// Dual-port storage array for the FIFO: one synchronous write port and one
// asynchronous (combinational) read port, giving show-ahead read data.
// Contents are deliberately not reset.
module fifomem
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                wclk,
  input  logic                wclken,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  // Store the incoming word only on an accepted write.
  always_ff @(posedge wclk) begin
    if (wclken) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head-of-queue data is presented without a clock edge.
  assign rdata = mem_q[raddr];

endmodule : fifomem

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary read/write pointers, occupancy
// count, registered status flags and sticky overflow/underflow errors.
// Data storage is delegated to fifomem.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DATASIZE   = DEF_DATASIZE,
  parameter int ADDRSIZE   = DEF_ADDRSIZE,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATASIZE-1:0]   wdata,
  input  logic                  rinc,
  output logic [DATASIZE-1:0]   rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDRSIZE:0]     count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDRSIZE);
  localparam int DEPTH = 1 << ADDRSIZE;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);
  localparam logic [PW-1:0] ONE_C    = PW'(1);

  // Almost-full at an empty FIFO only holds for a threshold of zero.
  localparam logic AFULL_RST = (AFULL_LVL <= 0) ? 1'b1 : 1'b0;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_en_s;
  logic          rd_en_s;

  // Acceptance is gated by the registered flags, so a write while full or a
  // read while empty is simply dropped.
  assign wr_en_s = winc && !wfull_q;
  assign rd_en_s = rinc && !rempty_q;

  // Next-state pointers, occupancy, status flags and sticky errors.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_en_s) begin
      wptr_d = wptr_q + ONE_C;
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_en_s) begin
      rptr_d = rptr_q + ONE_C;
    end else begin
      rptr_d = rptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // A new error event takes priority over a coincident clear.
    if (winc && wfull_q) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (rinc && rempty_q) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end

    // Flags are derived from the next count so they are valid right after
    // the edge that changes occupancy.
    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == {PW{1'b0}});
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  // Controller state register with asynchronous reset to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= {PW{1'b0}};
      rptr_q      <= {PW{1'b0}};
      count_q     <= {PW{1'b0}};
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= AFULL_RST;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifomem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .wclk   (clk),
    .wclken (wr_en_s),
    .waddr  (wptr_q[ADDRSIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rptr_q[ADDRSIZE-1:0]),
    .rdata  (rdata)
  );

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule : sync_fifo_ctrl

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (DATASIZE=8, ADDRSIZE=4).
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int fails = 0;

  sync_fifo_ctrl #(
    .DATASIZE   (8),
    .ADDRSIZE   (4),
    .AFULL_LVL  (12),
    .AEMPTY_LVL (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .err_clr       (err_clr),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},     32'(count), 32'd0);
    chk({tag, "_rempty"},    32'(rempty), 32'd1);
    chk({tag, "_wfull"},     32'(wfull), 32'd0);
    chk({tag, "_afull"},     32'(walmost_full), 32'd0);
    chk({tag, "_aempty"},    32'(ralmost_empty), 32'd1);
    chk({tag, "_overflow"},  32'(overflow), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    // Reset held across the first edge, then released between edges.
    #12;
    chk_reset_state("rst");
    rst_n = 1'b1;
    step();

    // Fill 0x00..0x0F; thresholds at 12 (almost full), 4 (almost empty).
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      step();
      chk("fill_count",  32'(count), 32'(i + 1));
      chk("fill_afull",  32'(walmost_full), ((i + 1) >= 12) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(ralmost_empty), ((i + 1) <= 4) ? 32'd1 : 32'd0);
      chk("fill_wfull",  32'(wfull), (i == 15) ? 32'd1 : 32'd0);
      chk("fill_rempty", 32'(rempty), 32'd0);
      chk("fill_head",   32'(rdata), 32'h00);
    end
    winc = 1'b0;

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rdata), 32'(i));
      rinc = 1'b1;
      step();
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    rinc = 1'b0;
    chk("drain_rempty", 32'(rempty), 32'd1);
    chk("drain_wfull",  32'(wfull), 32'd0);
    chk("drain_uflow",  32'(underflow), 32'd0);

    // Empty with simultaneous write and read: write wins, underflow sets.
    winc = 1'b1; rinc = 1'b1; wdata = 8'hA5;
    step();
    winc = 1'b0; rinc = 1'b0;
    chk("ebot_count",  32'(count), 32'd1);
    chk("ebot_rempty", 32'(rempty), 32'd0);
    chk("ebot_rdata",  32'(rdata), 32'hA5);
    chk("ebot_uflow",  32'(underflow), 32'd1);
    chk("ebot_oflow",  32'(overflow), 32'd0);

    // Clear with no new error.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_uflow", 32'(underflow), 32'd0);
    chk("clr_count", 32'(count), 32'd1);

    // Refill to full: queue = A5, 0x10..0x1E.
    for (int i = 0; i < 15; i++) begin
      winc = 1'b1; wdata = 8'(8'h10 + i);
      step();
    end
    winc = 1'b0;
    chk("full_count", 32'(count), 32'd16);
    chk("full_wfull", 32'(wfull), 32'd1);

    // Full with simultaneous write and read: read wins, overflow sets.
    winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    step();
    winc = 1'b0; rinc = 1'b0;
    chk("fbot_count", 32'(count), 32'd15);
    chk("fbot_oflow", 32'(overflow), 32'd1);
    chk("fbot_wfull", 32'(wfull), 32'd0);
    chk("fbot_rdata", 32'(rdata), 32'h10);

    // Back to full: queue = 0x10..0x1E, 0x77.
    winc = 1'b1; wdata = 8'h77;
    step();
    winc = 1'b0;
    chk("refull_wfull", 32'(wfull), 32'd1);
    err_clr = 1'b1;
    step();
    chk("clr_keep_oflow", 32'(overflow), 32'd0);
    // Clear coinciding with a write while full: the set wins.
    winc = 1'b1; wdata = 8'h99;
    step();
    winc = 1'b0; err_clr = 1'b0;
    chk("clrset_oflow", 32'(overflow), 32'd1);
    chk("clrset_count", 32'(count), 32'd16);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr2_oflow", 32'(overflow), 32'd0);

    // Drain; the rejected writes must not have disturbed the queue.
    for (int i = 0; i < 16; i++) begin
      chk("drain2_data", 32'(rdata), (i == 15) ? 32'h77 : 32'(8'h10 + i));
      rinc = 1'b1;
      step();
    end
    rinc = 1'b0;
    chk("drain2_rempty", 32'(rempty), 32'd1);
    chk("drain2_count",  32'(count), 32'd0);

    // Prime 8 entries 0x30..0x37, then 40 cycles of write+read.
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1; wdata = 8'(8'h30 + i);
      step();
    end
    winc = 1'b0;
    chk("prime_count", 32'(count), 32'd8);
    for (int i = 0; i < 40; i++) begin
      chk("stream_data", 32'(rdata), 32'(8'h30 + i));
      winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h38 + i);
      step();
      chk("stream_count", 32'(count), 32'd8);
    end
    winc = 1'b0; rinc = 1'b0;
    chk("stream_oflow", 32'(overflow), 32'd0);
    chk("stream_uflow", 32'(underflow), 32'd0);

    // Pop one (head 0x58) to reach count 7 with non-zero pointers.
    chk("pre_rst_head", 32'(rdata), 32'h58);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd7);

    // Asynchronous reset pulse between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    #2 rst_n = 1'b1;

    // First write after reset goes to address 0 and is visible at once.
    winc = 1'b1; wdata = 8'hC3;
    step();
    winc = 1'b0;
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_rdata", 32'(rdata), 32'hC3);
    chk("post_rst_addr0", 32'(dut.u_mem.mem_q[0]), 32'hC3);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // Hard bound in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_sync_fifo_ctrl
